// File: rtl/ddr_issue_scheduler_if.sv
// Bundle of decode-side, PHY-side and status signals for ddr_issue_scheduler.
// slave = scheduler side, master = environment side.
`ifndef DDR_UOP_WIDTH
`define DDR_UOP_WIDTH 16
`endif

interface ddr_issue_scheduler_if #(
  parameter int unsigned PKT_W      = `DDR_UOP_WIDTH * 4,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             ddr_valid;
  logic [PKT_W-1:0] ddr_uop;
  logic             sleep_req;
  logic [26:0]      sleep_cycles;
  logic             phy_valid;
  logic [PKT_W-1:0] phy_uop;
  logic             phy_ready;
  logic             decode_stall;
  logic             sleep_busy;
  logic [CNT_W-1:0] fifo_count;
  logic             err_overflow;
  logic             err_sleep;

  modport slave (
    input  ddr_valid, ddr_uop, sleep_req, sleep_cycles, phy_ready,
    output phy_valid, phy_uop, decode_stall, sleep_busy, fifo_count,
           err_overflow, err_sleep
  );

  modport master (
    output ddr_valid, ddr_uop, sleep_req, sleep_cycles, phy_ready,
    input  phy_valid, phy_uop, decode_stall, sleep_busy, fifo_count,
           err_overflow, err_sleep
  );
endinterface

// File: rtl/ddr_issue_scheduler.sv
// In-order DDR packet FIFO with PHY valid/ready issue and SLEEP drain/idle sequencing.
// Optional statistics counters enabled by defining DDR_ISSUE_STAT_EN.
`ifndef DDR_UOP_WIDTH
`define DDR_UOP_WIDTH 16
`endif

module ddr_issue_scheduler #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STALL_MARGIN = 2,
  parameter int unsigned PKT_W        = `DDR_UOP_WIDTH * 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ddr_issue_scheduler_if.slave  bus
`ifdef DDR_ISSUE_STAT_EN
  ,
  output logic [32*4-1:0]       sched_stat
`endif
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SLP_W  = 27;
  localparam int unsigned THRESH = FIFO_DEPTH - STALL_MARGIN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2
  } state_t;

  state_t           state;
  logic [PKT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] drain_cnt;
  logic [SLP_W-1:0] sleep_cnt;
  logic             ovf_q;
  logic             err_sleep_q;

  logic             empty;
  logic             full;
  logic             deq;
  logic             enq;
  logic             drop;
  logic [CNT_W-1:0] drain_calc;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));

  // Issue path: head of registered storage, suppressed while the PHY bus idles.
  assign bus.phy_valid = !empty && (state != SLEEP);
  assign bus.phy_uop   = empty ? '0 : mem[rd_ptr];

  assign deq  = bus.phy_valid && bus.phy_ready;
  assign enq  = bus.ddr_valid && (!full || deq);
  assign drop = bus.ddr_valid && full && !deq;

  // Packets older than the SLEEP request; a same-cycle enqueue is younger.
  assign drain_calc = count - CNT_W'(deq);

  assign bus.fifo_count   = count;
  assign bus.sleep_busy   = (state != IDLE);
  assign bus.err_overflow = ovf_q;
  assign bus.err_sleep    = err_sleep_q;
  assign bus.decode_stall = (count >= CNT_W'(THRESH)) ||
                            ((state == DRAIN) && (count >= CNT_W'(THRESH)));

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= bus.ddr_uop;
    end
  end

  // Pointers, occupancy and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // SLEEP sequencer: drain older packets, then hold the PHY bus idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      sleep_cnt   <= '0;
      err_sleep_q <= 1'b0;
    end else begin
      if (bus.sleep_req && (state != IDLE)) begin
        err_sleep_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.sleep_req) begin
            drain_cnt <= drain_calc;
            sleep_cnt <= bus.sleep_cycles;
            if (drain_calc != '0) begin
              state <= DRAIN;
            end else if (bus.sleep_cycles != '0) begin
              state <= SLEEP;
            end
          end
        end
        DRAIN: begin
          if (deq) begin
            drain_cnt <= drain_cnt - CNT_W'(1);
            if (drain_cnt == CNT_W'(1)) begin
              state <= (sleep_cnt != '0) ? SLEEP : IDLE;
            end
          end
        end
        SLEEP: begin
          sleep_cnt <= sleep_cnt - SLP_W'(1);
          if (sleep_cnt <= SLP_W'(1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR_ISSUE_STAT_EN
  logic [31:0] issued_pkts;
  logic [31:0] phy_stall_cyc;
  logic [31:0] drain_cyc;
  logic [31:0] sleep_cyc;

  // Free-running event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_pkts   <= '0;
      phy_stall_cyc <= '0;
      drain_cyc     <= '0;
      sleep_cyc     <= '0;
    end else begin
      if (deq) begin
        issued_pkts <= issued_pkts + 32'd1;
      end
      if (bus.phy_valid && !bus.phy_ready) begin
        phy_stall_cyc <= phy_stall_cyc + 32'd1;
      end
      if (state == DRAIN) begin
        drain_cyc <= drain_cyc + 32'd1;
      end
      if (state == SLEEP) begin
        sleep_cyc <= sleep_cyc + 32'd1;
      end
    end
  end

  assign sched_stat = {sleep_cyc, drain_cyc, phy_stall_cyc, issued_pkts};
`endif

endmodule

// File: tb/tb_ddr_issue_scheduler.sv
// Scoreboard bench for ddr_issue_scheduler: packets queued on drive, compared on PHY handshake.
`ifndef DDR_UOP_WIDTH
`define DDR_UOP_WIDTH 16
`endif

module tb_ddr_issue_scheduler;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned MARGIN = 2;
  localparam int unsigned PKT_W  = `DDR_UOP_WIDTH * 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [PKT_W-1:0] sb[$];

  ddr_issue_scheduler_if #(.PKT_W(PKT_W), .FIFO_DEPTH(DEPTH)) bus ();

`ifdef DDR_ISSUE_STAT_EN
  logic [32*4-1:0] sched_stat;
`endif

  ddr_issue_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .STALL_MARGIN(MARGIN),
    .PKT_W       (PKT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef DDR_ISSUE_STAT_EN
    ,
    .sched_stat(sched_stat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: each accepted PHY packet must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.phy_valid && bus.phy_ready) begin
      if (sb.size() == 0) check("sb_extra_issue", 128'(sb.size()), 128'd1);
      else                check("phy_uop", 128'(bus.phy_uop), 128'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.ddr_valid    = 1'b0;
    bus.ddr_uop      = '0;
    bus.sleep_req    = 1'b0;
    bus.sleep_cycles = '0;
    bus.phy_ready    = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push(input logic [PKT_W-1:0] p, input bit expect_issue);
    bus.ddr_valid = 1'b1;
    bus.ddr_uop   = p;
    if (expect_issue) sb.push_back(p);
    tick();
    bus.ddr_valid = 1'b0;
  endtask

  task automatic sleep_pulse(input logic [26:0] n);
    bus.sleep_req    = 1'b1;
    bus.sleep_cycles = n;
    tick();
    bus.sleep_req    = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (bus.fifo_count == '0 && sb.size() == 0) break;
      tick();
    end
    check(tag, 128'(bus.fifo_count), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int low_cyc;
    int busy_cyc;
    logic [PKT_W-1:0] pa;
    n_cmp = 0;
    n_err = 0;

    // Reset state, checked while reset is asserted.
    rst_n = 1'b0;
    bus.ddr_valid = 1'b0; bus.ddr_uop = '0; bus.sleep_req = 1'b0;
    bus.sleep_cycles = '0; bus.phy_ready = 1'b0;
    #1;
    check("rst_phy_valid", 128'(bus.phy_valid), 128'd0);
    check("rst_phy_uop", 128'(bus.phy_uop), 128'd0);
    check("rst_count", 128'(bus.fifo_count), 128'd0);
    check("rst_stall", 128'(bus.decode_stall), 128'd0);
    check("rst_busy", 128'(bus.sleep_busy), 128'd0);
    check("rst_flags", 128'({bus.err_overflow, bus.err_sleep}), 128'd0);

    // Streaming: A, B, C issue back-to-back one cycle after each write.
    do_reset();
    bus.phy_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pa = PKT_W'(64'hA000_0000_0000_0000 + 64'(i));
      check("stream_pre_valid", 128'(bus.phy_valid), 128'(i != 0));
      bus.ddr_valid = 1'b1;
      bus.ddr_uop   = pa;
      sb.push_back(pa);
      tick();
      check("stream_valid", 128'(bus.phy_valid), 128'd1);
      check("stream_head", 128'(bus.phy_uop), 128'(pa));
    end
    bus.ddr_valid = 1'b0;
    tick();
    check("stream_done_valid", 128'(bus.phy_valid), 128'd0);
    check("stream_done_count", 128'(bus.fifo_count), 128'd0);

    // Fill to full with PHY stalled; stall threshold, overflow, full+dequeue.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(PKT_W'(64'hB000_0000_0000_0000 + 64'(i)), 1'b1);
      check("fill_count", 128'(bus.fifo_count), 128'(i + 1));
      check("fill_stall", 128'(bus.decode_stall), 128'((i + 1) >= int'(DEPTH - MARGIN)));
    end
    check("full_ovf_clear", 128'(bus.err_overflow), 128'd0);
    push(PKT_W'(64'hBAD0_0000_0000_0009), 1'b0);
    check("ovf_flag", 128'(bus.err_overflow), 128'd1);
    check("ovf_count", 128'(bus.fifo_count), 128'd8);
    bus.phy_ready = 1'b1;
    push(PKT_W'(64'hB000_0000_0000_0008), 1'b1);
    check("full_deq_count", 128'(bus.fifo_count), 128'd8);
    wait_empty("fill_drain_count");
    check("ovf_sticky", 128'(bus.err_overflow), 128'd1);

    // SLEEP with 3 older packets and a same-cycle younger push D.
    do_reset();
    for (int i = 0; i < 3; i++) push(PKT_W'(64'hC000_0000_0000_0000 + 64'(i)), 1'b1);
    bus.ddr_valid = 1'b1;
    bus.ddr_uop   = PKT_W'(64'hD000_0000_0000_000D);
    sb.push_back(PKT_W'(64'hD000_0000_0000_000D));
    sleep_pulse(27'd5);
    bus.ddr_valid = 1'b0;
    check("drain_busy", 128'(bus.sleep_busy), 128'd1);
    check("drain_count", 128'(bus.fifo_count), 128'd4);
    check("drain_valid", 128'(bus.phy_valid), 128'd1);
    bus.phy_ready = 1'b1;
    low_cyc  = 0;
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.phy_valid && bus.fifo_count != '0) low_cyc++;
      if (bus.sleep_busy) busy_cyc++;
      if (sb.size() == 0 && !bus.phy_valid) break;
    end
    check("sleep_low_cycles", 128'(low_cyc), 128'd5);
    check("sleep_busy_cycles", 128'(busy_cyc), 128'd7);
    check("sleep_exit_busy", 128'(bus.sleep_busy), 128'd0);
    check("sleep_sb_empty", 128'(sb.size()), 128'd0);

    // Zero-length SLEEP stays IDLE; second request during SLEEP is flagged.
    do_reset();
    sleep_pulse(27'd0);
    check("zero_sleep_busy", 128'(bus.sleep_busy), 128'd0);
    tick();
    check("zero_sleep_busy2", 128'(bus.sleep_busy), 128'd0);
    sleep_pulse(27'd4);
    busy_cyc = bus.sleep_busy ? 1 : 0;
    check("err_sleep_pre", 128'(bus.err_sleep), 128'd0);
    sleep_pulse(27'd10);
    if (bus.sleep_busy) busy_cyc++;
    check("err_sleep_set", 128'(bus.err_sleep), 128'd1);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!bus.sleep_busy) break;
      busy_cyc++;
    end
    check("sleep_len_unchanged", 128'(busy_cyc), 128'd4);
    check("err_sleep_sticky", 128'(bus.err_sleep), 128'd1);

    // Asynchronous reset in the middle of SLEEP with queued packets.
    do_reset();
    sleep_pulse(27'd20);
    push(PKT_W'(64'hE000_0000_0000_0001), 1'b0);
    push(PKT_W'(64'hE000_0000_0000_0002), 1'b0);
    sleep_pulse(27'd3);
    check("mid_sleep_count", 128'(bus.fifo_count), 128'd2);
    check("mid_sleep_err", 128'(bus.err_sleep), 128'd1);
    check("mid_sleep_valid", 128'(bus.phy_valid), 128'd0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(bus.phy_valid), 128'd0);
    check("arst_count", 128'(bus.fifo_count), 128'd0);
    check("arst_busy", 128'(bus.sleep_busy), 128'd0);
    check("arst_flags", 128'({bus.err_overflow, bus.err_sleep}), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.phy_ready = 1'b1;
    push(PKT_W'(64'hE000_0000_0000_00EE), 1'b1);
    check("post_rst_valid", 128'(bus.phy_valid), 128'd1);
    check("post_rst_uop", 128'(bus.phy_uop), 128'(PKT_W'(64'hE000_0000_0000_00EE)));
    tick();
    check("post_rst_count", 128'(bus.fifo_count), 128'd0);

`ifdef DDR_ISSUE_STAT_EN
    // Statistics: 4 issues, 2 PHY stall cycles, 3 SLEEP cycles.
    do_reset();
    push(PKT_W'(64'hF000_0000_0000_0000), 1'b1);
    push(PKT_W'(64'hF000_0000_0000_0001), 1'b1);
    push(PKT_W'(64'hF000_0000_0000_0002), 1'b1);
    bus.phy_ready = 1'b1;
    push(PKT_W'(64'hF000_0000_0000_0003), 1'b1);
    wait_empty("stat_drain_count");
    sleep_pulse(27'd3);
    for (int i = 0; i < 20; i++) begin
      if (!bus.sleep_busy) break;
      tick();
    end
    check("stat_issued", 128'(sched_stat[31:0]), 128'd4);
    check("stat_phy_stall", 128'(sched_stat[63:32]), 128'd2);
    check("stat_drain", 128'(sched_stat[95:64]), 128'd0);
    check("stat_sleep", 128'(sched_stat[127:96]), 128'd3);
`endif

    check("sb_leftover", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_issue_scheduler.md
Name: ddr_issue_scheduler

Overview:
- Sits between decode_stage DDR outputs (ddr_valid / 4-slot ddr_uop bundle) and the PHY command interface.
- Buffers decoded DDR packets in a FIFO and issues them in order under a valid/ready handshake.
- Sequences SLEEP requests from execute: older packets drain first, then the PHY bus idles for the requested cycle count.
- Generates the front-end stall and sticky error flags.

Parameters:
- FIFO_DEPTH, 8, packet FIFO depth; power of 2, >= 4.
- STALL_MARGIN, 2, free-entry threshold for decode_stall; covers fetch->decode in-flight packets.
- PKT_W, `DDR_UOP_WIDTH*4, width of one 4-slot packet.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ddr_valid  in  1  packet valid from decode.
- ddr_uop  in  PKT_W  4-slot DDR uop packet.
- sleep_req  in  1  one-cycle SLEEP pulse from execute.
- sleep_cycles  in  27  SLEEP length in cycles.
- phy_valid  out  1  packet presented to PHY.
- phy_uop  out  PKT_W  FIFO head packet.
- phy_ready  in  1  PHY accepts packet.
- decode_stall  out  1  front end must hold.
- sleep_busy  out  1  SLEEP pending or active.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy.
- err_overflow  out  1  sticky: packet dropped while full.
- err_sleep  out  1  sticky: sleep_req while sleep_busy.

Behaviour:
- Reset (rst_n low, async): FIFO empty, state IDLE, all outputs 0, counters 0, sticky flags cleared. Reset mid-SLEEP or mid-DRAIN discards all queued packets.
- FIFO is show-ahead: phy_uop = head entry, registered storage. A write at cycle t is visible on phy_valid at t+1; no bypass.
- Throughput is 1 packet/cycle while phy_ready is high.
- Handshake: phy_valid, once high, holds high with stable phy_uop until phy_ready. Dequeue occurs on phy_valid & phy_ready.
- Enqueue on ddr_valid when not full.
- Full plus same-cycle dequeue: the write is accepted and count is unchanged.
- Full without dequeue: the packet is dropped, err_overflow is set, and count is unchanged.
- Empty: phy_valid = 0, phy_uop = 0.
- decode_stall = (FIFO_DEPTH - fifo_count) <= STALL_MARGIN, or state == DRAIN with fifo_count >= FIFO_DEPTH-STALL_MARGIN. Combinational from registered count.
- FSM:
  - IDLE: phy_valid = !empty.
    - On sleep_req: compute drain = fifo_count - (dequeue this cycle ? 1 : 0).
    - A packet enqueued in the same cycle as sleep_req is younger and is not counted in drain.
    - drain > 0 -> DRAIN (load drain_cnt = drain, sleep_cnt = sleep_cycles).
    - drain == 0 and sleep_cycles > 0 -> SLEEP.
    - drain == 0 and sleep_cycles == 0 -> stay IDLE.
  - DRAIN: issue normally. drain_cnt decrements per dequeue. On the dequeue that makes drain_cnt 0: SLEEP if sleep_cnt > 0, else IDLE.
  - SLEEP: phy_valid forced 0. Enqueue continues. sleep_cnt decrements each cycle; at sleep_cnt == 1 -> IDLE. phy_valid is low for exactly sleep_cycles cycles in SLEEP.
- sleep_busy = (state != IDLE).
- sleep_req while sleep_busy is ignored and sets err_sleep.
- sleep_cycles is 27-bit unsigned, max 2^27-1; no wrap.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is one bit wider.

Optional Feature:
- Macro: DDR_ISSUE_STAT_EN.
- Defined: adds output sched_stat [32*4-1:0] = {sleep_cyc, drain_cyc, phy_stall_cyc, issued_pkts}.
  - issued_pkts: +1 per dequeue.
  - phy_stall_cyc: +1 per cycle with phy_valid & !phy_ready.
  - drain_cyc: +1 per cycle in DRAIN.
  - sleep_cyc: +1 per cycle in SLEEP.
  - All counters are 32-bit, wrap at 2^32, and are cleared only by reset.
- Undefined: no port, no counters, no added logic.

Test Plan:
- Reset, phy_ready=1, ddr_valid for 3 consecutive cycles with packets A, B, C -> phy_valid high 3 consecutive cycles starting one cycle after A; phy_uop = A, B, C; fifo_count returns to 0.
- phy_ready=0, 8 pushes into FIFO_DEPTH=8 -> decode_stall high from count 6; fifo_count=8. A 9th push sets err_overflow=1 and count stays 8. Push plus phy_ready=1 in the same cycle at full -> accepted, count stays 8.
- 3 packets queued, phy_ready=0, sleep_req with sleep_cycles=5 and a same-cycle push D -> DRAIN with drain_cnt=3. After 3 handshakes: phy_valid=0 for exactly 5 cycles, then D issues. sleep_busy high from the cycle after sleep_req until SLEEP exits.
- Empty FIFO, sleep_req with sleep_cycles=0 -> state stays IDLE, sleep_busy stays 0. Second sleep_req during an active SLEEP -> err_sleep=1, sleep length unchanged.
- rst_n asserted mid-SLEEP with 2 packets queued -> immediately phy_valid=0, fifo_count=0, sleep_busy=0, flags cleared. After release, a push issues after 1 cycle.
- With DDR_ISSUE_STAT_EN: 4 issues, 2 PHY stall cycles, SLEEP of 3 -> sched_stat fields issued_pkts=4, phy_stall_cyc=2, sleep_cyc=3.
